// File: rtl/aes_one_round.sv
// aes_one_round: one registered AES-128 encryption round with on-the-fly key
// expansion. Applies SubBytes, ShiftRows and MixColumns to state_in, derives
// the next round key from key_in and rcon, and registers both results. The
// state output is the transformed state XORed with the new round key.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears both outputs
//   state_in   128-bit round input state (byte 0 in [127:120], column-major)
//   key_in     128-bit current round key {w0,w1,w2,w3}
//   rcon       8-bit round constant for this expansion step
//   state_out  128-bit registered round output
//   key_out    128-bit registered next round key
module aes_one_round (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] state_out,
  output logic [127:0] key_out
);

  // FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255-int'(x)) +: 8];
  endfunction

  // Multiply by 2 in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [127:0] key_d, state_d;
  logic [127:0] key_q, state_q;
  logic [31:0]  rot_w3, sub_t;
  logic [7:0]   sr [16];
  logic [7:0]   a0, a1, a2, a3;
  logic [127:0] mixed;

  // Key expansion: t = SubWord(RotWord(w3)) ^ {rcon,0}, then a running XOR chain.
  always_comb begin
    rot_w3 = {key_in[23:0], key_in[31:24]};
    sub_t  = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]), sbox(rot_w3[15:8]), sbox(rot_w3[7:0])}
             ^ {rcon, 24'h0};
    key_d[127:96] = key_in[127:96] ^ sub_t;
    key_d[95:64]  = key_in[95:64]  ^ key_d[127:96];
    key_d[63:32]  = key_in[63:32]  ^ key_d[95:64];
    key_d[31:0]   = key_in[31:0]   ^ key_d[63:32];
  end

  // SubBytes fused with ShiftRows: output (row r, col c) takes input (r, c+r mod 4).
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sbox(state_in[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

  always_comb begin
    mixed = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mixed[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mixed[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mixed[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mixed[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    state_d = mixed ^ key_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  assign state_out = state_q;
  assign key_out   = key_q;

endmodule

// File: tb/tb_aes_one_round.sv
module tb_aes_one_round;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] state_in = '0;
  logic [127:0] key_in = '0;
  logic [7:0]   rcon = '0;
  logic [127:0] state_out, key_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] exp_q [$];  // {state, key}

  localparam logic [127:0] R1S  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1SO = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] R1KO = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R2SO = 128'haa8f5f0361dde3ef82d24ad26832469a;
  localparam logic [127:0] R2KO = 128'hf2c295f27a96b9435935807a7359f67f;

  aes_one_round u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state_in  (state_in),
    .key_in    (key_in),
    .rcon      (rcon),
    .state_out (state_out),
    .key_out   (key_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: S-box from GF inverse plus affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv = '0;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) begin
      if (x != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic model(input logic [127:0] s, input logic [127:0] k, input logic [7:0] rc,
                       output logic [127:0] so, output logic [127:0] ko);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [31:0] w3, tw;
    w3 = k[31:0];
    tw = {m_sbox(w3[23:16]) ^ rc, m_sbox(w3[15:8]), m_sbox(w3[7:0]), m_sbox(w3[31:24])};
    ko[127:96] = k[127:96] ^ tw;
    ko[95:64]  = k[95:64] ^ ko[127:96];
    ko[63:32]  = k[63:32] ^ ko[95:64];
    ko[31:0]   = k[31:0] ^ ko[63:32];
    for (int i = 0; i < 16; i++) b[i] = m_sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        so[127-8*(4*c+r) -: 8] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                                 ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      end
    end
    so ^= ko;
  endtask

  task automatic drive(input logic [127:0] s, input logic [127:0] k, input logic [7:0] rc,
                       input logic [127:0] es, input logic [127:0] ek);
    state_in = s;
    key_in   = k;
    rcon     = rc;
    exp_q.push_back({es, ek});
  endtask

  task automatic edge_and_check(input string tag);
    logic [255:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_state"}, state_out, e[255:128]);
      check_eq({tag, "_key"}, key_out, e[127:0]);
    end
  endtask

  initial begin
    logic [127:0] rs, rk, es, ek;
    logic [7:0] rc;

    #2;
    check_eq("reset_state", state_out, '0);
    check_eq("reset_key", key_out, '0);
    state_in = R1S;
    key_in   = R1K;
    rcon     = 8'h01;
    @(posedge clk);
    #1;
    check_eq("held_in_reset_state", state_out, '0);
    check_eq("held_in_reset_key", key_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer rounds, back to back.
    drive(R1S, R1K, 8'h01, R1SO, R1KO);
    edge_and_check("fips_r1");
    drive(R1SO, R1KO, 8'h02, R2SO, R2KO);
    edge_and_check("fips_r2");
    drive('0, '0, 8'h00, '0, {4{32'h63636363}});
    edge_and_check("zero_rcon0");
    drive('0, '0, 8'h01, {4{32'h01000000}}, {4{32'h62636363}});
    edge_and_check("zero_rcon1");

    // Randomised rounds against the reference model.
    for (int i = 0; i < 6; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      rc = 8'($urandom);
      model(rs, rk, rc, es, ek);
      drive(rs, rk, rc, es, ek);
      edge_and_check("random");
    end

    // Inputs wiggled between edges must not matter.
    drive('0, '0, 8'h00, '0, {4{32'h63636363}});
    edge_and_check("toggle_a");
    #2;
    state_in = R1S;
    key_in   = R1K;
    rcon     = 8'h36;
    #1;
    check_eq("toggle_mid_state", state_out, '0);
    check_eq("toggle_mid_key", key_out, {4{32'h63636363}});
    drive('0, '0, 8'h01, {4{32'h01000000}}, {4{32'h62636363}});
    edge_and_check("toggle_b");

    // Asynchronous reset between edges while outputs are nonzero.
    drive(R1S, R1K, 8'h01, R1SO, R1KO);
    edge_and_check("pre_reset");
    state_in = R1SO;
    key_in   = R1KO;
    rcon     = 8'h02;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", state_out, '0);
    check_eq("async_rst_key", key_out, '0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_state", state_out, '0);
    check_eq("rst_hold_key", key_out, '0);
    state_in = R1S;
    key_in   = R1K;
    rcon     = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    drive(R1S, R1K, 8'h01, R1SO, R1KO);
    edge_and_check("after_release");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
